// File: rtl/button_debouncer_if.sv
// Button debouncer signal bundle: raw level in, debounced level, edge pulses and press count out.
interface button_debouncer_if #(
  parameter int unsigned CNT_W = 8
) ();
  logic             in_i;
  logic             level_o;
  logic             press_o;
  logic             release_o;
  logic [CNT_W-1:0] press_count_o;

  modport master (
    output in_i,
    input  level_o,
    input  press_o,
    input  release_o,
    input  press_count_o
  );

  modport slave (
    input  in_i,
    output level_o,
    output press_o,
    output release_o,
    output press_count_o
  );
endinterface

// File: rtl/button_debouncer.sv
// Debounces a synchronized button level: a new level is accepted after STABLE_CYCLES identical
// samples, with registered press/release pulses and a wrapping press counter.
module button_debouncer #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input logic               clk,
  input logic               rst,
  button_debouncer_if.slave bus
);

  localparam int unsigned    CntW   = $clog2(STABLE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);

  localparam logic [1:0] StLow     = 2'd0;
  localparam logic [1:0] StArmHigh = 2'd1;
  localparam logic [1:0] StHigh    = 2'd2;
  localparam logic [1:0] StArmLow  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    count_d   = count_q;
    case (state_q)
      StLow: begin
        if (bus.in_i) begin
          state_d = StArmHigh;
          cnt_d   = CntW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      StArmHigh: begin
        if (!bus.in_i) begin
          state_d = StLow;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d = StHigh;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
          count_d = count_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHigh: begin
        if (!bus.in_i) begin
          state_d = StArmLow;
          cnt_d   = CntW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      StArmLow: begin
        if (bus.in_i) begin
          state_d = StHigh;
          cnt_d   = '0;
        end else if (cnt_q == CntMax) begin
          state_d   = StLow;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StLow;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StLow;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      count_q   <= count_d;
    end
  end

  assign bus.level_o       = level_q;
  assign bus.press_o       = press_q;
  assign bus.release_o     = release_q;
  assign bus.press_count_o = count_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Randomized and directed bench for button_debouncer, checked by a run-length reference model.
module tb_button_debouncer;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  typedef struct packed {
    logic         level;
    logic         press;
    logic         rel;
    logic [W-1:0] count;
  } exp_t;

  logic clk;
  logic rst;

  button_debouncer_if #(.CNT_W(W)) bus_if ();

  button_debouncer #(
    .STABLE_CYCLES(N),
    .CNT_W        (W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: accepted level plus length of the current run of samples that disagree.
  logic         m_level = 1'b0;
  int           m_run   = 0;
  logic [W-1:0] m_cnt   = '0;

  task automatic step(input logic r, input logic v);
    exp_t e;
    @(negedge clk);
    rst          = r;
    bus_if.in_i  = v;
    e.press      = 1'b0;
    e.rel        = 1'b0;
    if (r) begin
      m_level = 1'b0;
      m_run   = 0;
      m_cnt   = '0;
    end else begin
      if (v != m_level) m_run = m_run + 1;
      else m_run = 0;
      if (m_run == N) begin
        m_level = v;
        m_run   = 0;
        if (v) begin
          e.press = 1'b1;
          m_cnt   = m_cnt + 1'b1;
        end else begin
          e.rel = 1'b1;
        end
      end
    end
    e.level = m_level;
    e.count = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) step(1'b0, v);
  endtask

  // Monitor: every edge the DUT presents a fresh registered output word.
  always @(posedge clk) begin
    exp_t e;
    exp_t a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.level = bus_if.level_o;
      a.press = bus_if.press_o;
      a.rel   = bus_if.release_o;
      a.count = bus_if.press_count_o;
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL outputs t=%0t got lvl=%b prs=%b rel=%b cnt=%0d want lvl=%b prs=%b rel=%b cnt=%0d",
                 $time, a.level, a.press, a.rel, a.count, e.level, e.press, e.rel, e.count);
      end
    end
  end

  initial begin
    int len;
    logic v;
    rst         = 1'b1;
    bus_if.in_i = 1'b0;

    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    hold(1'b0, 3);

    // Clean press, then release from HIGH.
    hold(1'b1, 10);
    hold(1'b0, 6);

    // Bounce that never reaches four consecutive ones.
    hold(1'b1, 3); hold(1'b0, 1); hold(1'b1, 3); hold(1'b0, 1);
    hold(1'b0, 5);

    // Glitch while HIGH.
    hold(1'b1, 6);
    hold(1'b0, 3); hold(1'b1, 2); hold(1'b0, 1); hold(1'b1, 3);
    hold(1'b0, 6);

    // 257 clean presses from reset exercise the counter wrap.
    step(1'b1, 1'b0);
    for (int i = 0; i < 257; i++) begin
      hold(1'b1, 5);
      hold(1'b0, 5);
    end

    // Reset lands on the edge that would accept the 4th one; in stays high through it.
    step(1'b1, 1'b0);
    hold(1'b0, 2);
    hold(1'b1, 3);
    step(1'b1, 1'b1);
    hold(1'b1, 8);
    hold(1'b0, 6);

    // Reset asserted while in is already held high for a while.
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    hold(1'b1, 6);

    // Random bursts with occasional reset.
    for (int b = 0; b < 600; b++) begin
      v   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 7));
      for (int i = 0; i < len; i++)
        step((i == 0) && ($urandom_range(0, 59) == 0), v);
    end

    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
